dcm_lock_supervisor: RTL and testbench

//  Sequences the xclk->clk75Mhz DCM_SP: drives its RST pin, watches LOCKED and CLKIN-stopped
//  (STATUS[1]), times out and retries failed locks, and holds the design off clk75Mhz until lock is stable.

---
 rtl/dcm_lock_supervisor.sv | 136 +++++++++++++
 tb/tb_dcm_lock_supervisor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_supervisor.sv
// dcm_lock_supervisor: sequences the DCM_SP reset, retries failed locks and
// holds clk_ready low until LOCKED has been stable for STABLE_CYCLES.
module dcm_lock_supervisor #(
    parameter int RST_CYCLES    = 30,
    parameter int LOCK_TIMEOUT  = 4095,
    parameter int STABLE_CYCLES = 16,
    parameter int MAX_RETRIES   = 7
) (
    input  logic       xclk,
    input  logic       cpld_reset,
    input  logic       i_sw_reset_req,
    input  logic       i_dcm_locked,
    input  logic       i_dcm_clkin_stop,
    output logic       o_dcm_rst,
    output logic       o_clk_ready,
    output logic       o_lock_fail,
    output logic [3:0] o_retry_count,
    output logic [7:0] o_lost_lock_count,
    output logic [2:0] o_state
);
    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t      r_state;
    logic [11:0] r_timer;
    logic        r_lock_meta, r_locked_s, r_stop_meta, r_stop_s, r_sw_d;
    logic        r_dcm_rst, r_clk_ready, r_lock_fail;
    logic [3:0]  r_retry_count;
    logic [7:0]  r_lost_lock_count;
    logic        w_sw_req;

    assign w_sw_req          = i_sw_reset_req & ~r_sw_d;
    assign o_dcm_rst         = r_dcm_rst;
    assign o_clk_ready       = r_clk_ready;
    assign o_lock_fail       = r_lock_fail;
    assign o_retry_count     = r_retry_count;
    assign o_lost_lock_count = r_lost_lock_count;
    assign o_state           = r_state;

    always_ff @(posedge xclk or negedge cpld_reset) begin
        if (!cpld_reset) begin
            r_lock_meta <= 1'b0;
            r_locked_s  <= 1'b0;
            r_stop_meta <= 1'b0;
            r_stop_s    <= 1'b0;
            r_sw_d      <= 1'b0;
        end else begin
            r_lock_meta <= i_dcm_locked;
            r_locked_s  <= r_lock_meta;
            r_stop_meta <= i_dcm_clkin_stop;
            r_stop_s    <= r_stop_meta;
            r_sw_d      <= i_sw_reset_req;
        end
    end

    // A software request outranks every other transition, including a lock loss seen on the same edge.
    always_ff @(posedge xclk or negedge cpld_reset) begin
        if (!cpld_reset) begin
            r_state           <= RESET;
            r_timer           <= '0;
            r_dcm_rst         <= 1'b1;
            r_clk_ready       <= 1'b0;
            r_lock_fail       <= 1'b0;
            r_retry_count     <= '0;
            r_lost_lock_count <= '0;
        end else if (w_sw_req) begin
            r_state       <= RESET;
            r_timer       <= '0;
            r_dcm_rst     <= 1'b1;
            r_clk_ready   <= 1'b0;
            r_lock_fail   <= 1'b0;
            r_retry_count <= '0;
        end else begin
            case (r_state)
                RESET: begin
                    if (r_timer == 12'(RST_CYCLES - 1)) begin
                        r_state   <= WAIT_LOCK;
                        r_timer   <= '0;
                        r_dcm_rst <= 1'b0;
                    end else
                        r_timer <= r_timer + 12'd1;
                end
                WAIT_LOCK: begin
                    if (r_locked_s) begin
                        r_state <= STABLE;
                        r_timer <= '0;
                    end else if (r_timer == 12'(LOCK_TIMEOUT - 1)) begin
                        r_timer   <= '0;
                        r_dcm_rst <= 1'b1;
                        if (r_retry_count == 4'(MAX_RETRIES)) begin
                            r_state     <= FAIL;
                            r_lock_fail <= 1'b1;
                        end else begin
                            r_state       <= RESET;
                            r_retry_count <= r_retry_count + 4'd1;
                        end
                    end else
                        r_timer <= r_timer + 12'd1;
                end
                STABLE: begin
                    if (!r_locked_s) begin
                        r_state <= WAIT_LOCK;
                        r_timer <= '0;
                    end else if (r_timer == 12'(STABLE_CYCLES - 1)) begin
                        r_state     <= RUN;
                        r_timer     <= '0;
                        r_clk_ready <= 1'b1;
                    end else
                        r_timer <= r_timer + 12'd1;
                end
                RUN: begin
                    if (!r_locked_s || r_stop_s) begin
                        r_state           <= RESET;
                        r_timer           <= '0;
                        r_dcm_rst         <= 1'b1;
                        r_clk_ready       <= 1'b0;
                        r_lost_lock_count <= r_lost_lock_count + {7'd0, r_lost_lock_count != 8'hff};
                    end
                end
                FAIL: begin
                end
                default: begin
                    r_state     <= RESET;
                    r_timer     <= '0;
                    r_dcm_rst   <= 1'b1;
                    r_clk_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// tb_dcm_lock_supervisor: directed sequencing scenarios with arithmetic expectations,
// then randomized stimulus against a state-level reference model.
module tb_dcm_lock_supervisor;
    logic       xclk = 1'b0;
    logic       cpld_reset = 1'b0;
    logic       sw = 1'b0, locked = 1'b0, stop = 1'b0;
    logic       dcm_rst, clk_ready, lock_fail;
    logic [3:0] retry_count;
    logic [7:0] lost_lock_count;
    logic [2:0] state;
    int         n_tests = 0, n_fail = 0;
    bit         mchk = 0;

    dcm_lock_supervisor dut (
        .xclk(xclk), .cpld_reset(cpld_reset), .i_sw_reset_req(sw),
        .i_dcm_locked(locked), .i_dcm_clkin_stop(stop),
        .o_dcm_rst(dcm_rst), .o_clk_ready(clk_ready), .o_lock_fail(lock_fail),
        .o_retry_count(retry_count), .o_lost_lock_count(lost_lock_count), .o_state(state)
    );

    always #5 xclk = ~xclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase, cycles spent in phase, counters, and input sample history.
    int m_ph, m_t, m_rc, m_lf, m_llc;
    bit l1, l2, s1, s2, swp;

    function automatic logic [17:0] dut_vec();
        return {state, dcm_rst, clk_ready, lock_fail, retry_count, lost_lock_count};
    endfunction

    function automatic logic [17:0] model_vec();
        logic [2:0] ph = 3'(m_ph);
        return {ph, 1'(m_ph == 0 || m_ph == 4), 1'(m_ph == 3), 1'(m_lf), 4'(m_rc), 8'(m_llc)};
    endfunction

    task automatic m_reset();
        m_ph = 0; m_t = 0; m_rc = 0; m_lf = 0; m_llc = 0;
        l1 = 0; l2 = 0; s1 = 0; s2 = 0; swp = 0;
    endtask

    task automatic m_step();
        int nph;
        bit req;
        if (!cpld_reset) begin
            m_reset();
            return;
        end
        req = sw && !swp;
        nph = m_ph;
        if (req) begin
            nph = 0; m_rc = 0; m_lf = 0;
        end else if (m_ph == 0 && m_t == 29) nph = 1;
        else if (m_ph == 1 && l2) nph = 2;
        else if (m_ph == 1 && m_t == 4094) begin
            if (m_rc == 7) begin nph = 4; m_lf = 1; end
            else begin nph = 0; m_rc++; end
        end else if (m_ph == 2 && !l2) nph = 1;
        else if (m_ph == 2 && m_t == 15) nph = 3;
        else if (m_ph == 3 && (!l2 || s2)) begin
            nph = 0;
            m_llc = (m_llc < 255) ? m_llc + 1 : 255;
        end
        m_t = (req || nph != m_ph) ? 0 : m_t + 1;
        m_ph = nph;
        l2 = l1; l1 = locked; s2 = s1; s1 = stop; swp = sw;
    endtask

    task automatic tick();
        m_step();
        @(posedge xclk);
        #1;
        if (mchk) check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    initial begin
        int n, to, rises;
        bit prev;
        m_reset();
        #12;
        check("reset_vals", 32'(dut_vec()), 32'({3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
        @(posedge xclk);
        #1 cpld_reset = 1'b1;

        n = 0;
        while (dcm_rst && n < 100) begin tick(); n++; end
        check("t1_rst_len", n, 30);
        repeat (50) tick();
        locked = 1'b1;
        n = 0;
        while (!clk_ready && n < 100) begin tick(); n++; end
        check("t1_lock_lat", n - 1, 18);
        check("t1_state", state, 3);
        check("t1_dcm_rst", dcm_rst, 0);

        locked = 1'b0;
        n = 0;
        while (clk_ready && n < 10) begin tick(); n++; end
        check("t3_drop_lat", n, 3);
        repeat (2) tick();
        locked = 1'b1;
        check("t3_llc", lost_lock_count, 1);
        check("t3_state", state, 0);
        n = 2;
        while (dcm_rst && n < 100) begin tick(); n++; end
        check("t3_rst_len", n, 30);
        n = 0;
        while (!clk_ready && n < 100) begin tick(); n++; end
        check("t3_relock", clk_ready, 1);
        check("t3_retry", retry_count, 0);

        locked = 1'b0;
        tick(); tick();
        check("t6_pre", state, 3);
        sw = 1'b1;
        tick();
        check("t6_state", state, 0);
        check("t6_llc", lost_lock_count, 1);
        sw = 1'b0; locked = 1'b1;
        n = 0;
        while (!clk_ready && n < 100) begin tick(); n++; end
        check("t6_relock", clk_ready, 1);

        to = 0;
        for (int k = 1; k <= 300; k++) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            n = 0;
            while (clk_ready && n < 10) begin tick(); n++; end
            while (!clk_ready && n < 200) begin tick(); n++; end
            if (n >= 200) to++;
            if (k == 100) check("t4_llc_100", lost_lock_count, 101);
        end
        check("t4_timeouts", to, 0);
        check("t4_llc_sat", lost_lock_count, 255);

        locked = 1'b0; sw = 1'b1;
        tick();
        sw = 1'b0;
        n = 0; rises = 0; prev = dcm_rst;
        while (state != 3'd4 && n < 40000) begin
            tick();
            n++;
            if (dcm_rst && !prev) rises++;
            prev = dcm_rst;
        end
        check("t2_time", n, 8 * (30 + 4095));
        check("t2_rst_rises", rises, 8);
        check("t2_lock_fail", lock_fail, 1);
        check("t2_retry", retry_count, 7);
        check("t2_dcm_rst", dcm_rst, 1);
        repeat (20) tick();
        check("t2_sticky", {state, lock_fail}, {3'd4, 1'b1});

        sw = 1'b1;
        tick();
        check("t5_state", state, 0);
        check("t5_clear", {lock_fail, retry_count}, 0);
        check("t5_llc_kept", lost_lock_count, 255);
        sw = 1'b0; locked = 1'b1;
        n = 0;
        while (!clk_ready && n < 200) begin tick(); n++; end
        check("t5_run", state, 3);

        sw = 1'b1;
        tick();
        sw = 1'b0;
        n = 0;
        while (state != 3'd2 && n < 100) begin tick(); n++; end
        check("t7_stable", state, 2);
        #2 cpld_reset = 1'b0;
        #1 check("t7_async", 32'(dut_vec()), 32'({3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));

        m_reset();
        tick(); tick();
        cpld_reset = 1'b1;
        mchk = 1;
        for (int c = 0; c < 6000; c++) begin
            if (locked) locked = ($urandom_range(59) != 0);
            else locked = ($urandom_range(7) == 0);
            stop = ($urandom_range(199) == 0);
            if ($urandom_range(99) == 0) sw = ~sw;
            tick();
        end
        mchk = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
